// File: rtl/r500_dbg_pkg.sv
// Shared types, ASCII constants and the nibble-to-hex helper for the signature dumper.
package r500_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        SEND,
        DONE
    } sig_state_t;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CHAR_LAST = 8;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Lowercase hex digit for one nibble.
    function automatic logic [7:0] nib2hex(input logic [3:0] i_nib);
        if (i_nib < 4'd10) begin
            return ASCII_0 + 8'(i_nib);
        end
        return ASCII_A + 8'(i_nib) - 8'd10;
    endfunction

endpackage

// File: rtl/sig_word_serializer.sv
// Turns one 32-bit word into 8 hex chars plus LF on a valid/ready byte stream.
module sig_word_serializer
    import r500_dbg_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [WORD_W-1:0]  i_word,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [BYTE_W-1:0]  o_data,
    output logic               o_last_ack_c
);

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic              r_valid;
    logic [BYTE_W-1:0] r_data;

    logic              w_fire;
    logic              w_at_lf;
    logic [WORD_W-1:0] w_shift;

    assign w_fire       = r_valid & i_ready;
    assign w_at_lf      = (r_idx == IDX_W'(CHAR_LAST));
    assign w_shift      = r_word << NIB_W;
    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_last_ack_c = w_fire & w_at_lf;

    // Char pointer, shifting word and the registered output byte; hold while not accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= nib2hex(i_word[WORD_W-1 -: NIB_W]);
        end else if (w_fire) begin
            if (w_at_lf) begin
                r_valid <= 1'b0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_word <= w_shift;
                r_data <= (r_idx == IDX_W'(CHAR_LAST - 1)) ? ASCII_LF
                                                           : nib2hex(w_shift[WORD_W-1 -: NIB_W]);
            end
        end
    end

endmodule

// File: rtl/sig_dump_streamer.sv
// Completion monitor: on a store of 1 to TOHOST, halts the core and streams the
// signature region out as hex text, one word per line.
module sig_dump_streamer
    import r500_dbg_pkg::*;
#(
    parameter logic [31:0] SIG_BEGIN = 32'h0000_5000,
    parameter logic [31:0] SIG_END   = 32'h0000_8000,
    parameter logic [31:0] TOHOST    = 32'h0000_5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_en,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        core_halt,
    output logic        done
);

    // Word-aligned addresses are assumed throughout the address walk.
    if ((SIG_BEGIN[1:0] != 2'b00) || (SIG_END[1:0] != 2'b00) || (TOHOST[1:0] != 2'b00)) begin : g_cfg_misaligned
        $error("sig_dump_streamer: SIG_BEGIN, SIG_END and TOHOST must be word aligned");
    end

    sig_state_t        r_state;
    sig_state_t        w_state_nxt;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] w_addr_nxt;
    logic [WORD_W-1:0] w_addr_inc;
    logic              r_rd_en;
    logic              r_halt;
    logic              r_done;
    logic              w_trigger;
    logic              w_load;
    logic              w_last_ack;

    assign w_trigger  = st_en && (st_addr == TOHOST) && (st_data == 32'h1);
    assign w_addr_inc = r_addr + 32'd4;

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_addr;
    assign core_halt = r_halt;
    assign done      = r_done;

    // Next-state and address-walk decode.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    if (SIG_END <= SIG_BEGIN) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = READ;
                        w_addr_nxt  = SIG_BEGIN;
                    end
                end
            end
            READ: w_state_nxt = CAPT;
            CAPT: begin
                w_load      = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_last_ack) begin
                    w_addr_nxt  = w_addr_inc;
                    w_state_nxt = (w_addr_inc >= SIG_END) ? DONE : READ;
                end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, address and registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= SIG_BEGIN;
            r_rd_en <= 1'b0;
            r_halt  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_rd_en <= (w_state_nxt == READ);
            r_halt  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    sig_word_serializer u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_word       (rd_data),
        .i_ready      (tx_ready),
        .o_valid      (tx_valid),
        .o_data       (tx_data),
        .o_last_ack_c (w_last_ack)
    );

endmodule

// File: tb/tb_sig_dump_streamer.sv
// Directed bench for sig_dump_streamer: trigger filtering, stream content and
// timing, backpressure hold, mid-dump reset and the empty-region configuration.
module tb_sig_dump_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_en;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        core_halt;
    logic        done;

    logic        rd_en2;
    logic [31:0] rd_addr2;
    logic [31:0] rd_data2;
    logic        tx_valid2;
    logic [7:0]  tx_data2;
    logic        core_halt2;
    logic        done2;

    int n_checks = 0;
    int n_errors = 0;
    int bad2     = 0;

    logic [7:0] exp_b [18] = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0a,
                               8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h61, 8'h0a};

    always #5 clk = ~clk;

    sig_dump_streamer #(
        .SIG_BEGIN (32'h100),
        .SIG_END   (32'h108),
        .TOHOST    (32'h200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_en     (st_en),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .core_halt (core_halt),
        .done      (done)
    );

    sig_dump_streamer #(
        .SIG_BEGIN (32'h100),
        .SIG_END   (32'h100),
        .TOHOST    (32'h200)
    ) dut_empty (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_en     (st_en),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .rd_en     (rd_en2),
        .rd_addr   (rd_addr2),
        .rd_data   (rd_data2),
        .tx_valid  (tx_valid2),
        .tx_data   (tx_data2),
        .tx_ready  (tx_ready),
        .core_halt (core_halt2),
        .done      (done2)
    );

    // Synchronous read memory model: data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            case (rd_addr)
                32'h100: rd_data <= 32'hDEADBEEF;
                32'h104: rd_data <= 32'h0000000A;
                default: rd_data <= 32'hBAD0BAD0;
            endcase
        end
    end

    // The empty-region instance must never read or transmit.
    always @(posedge clk) begin
        if (rd_en2 || tx_valid2) bad2 = bad2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks = n_checks + 1;
        if (obs !== expv) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
        chk({tag, "_rd_addr"},   rd_addr,        32'h100);
        chk({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
        chk({tag, "_tx_data"},   32'(tx_data),   32'd0);
        chk({tag, "_core_halt"}, 32'(core_halt), 32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    task automatic do_trigger();
        st_en   = 1'b1;
        st_addr = 32'h200;
        st_data = 32'h1;
        tick();
        st_en   = 1'b0;
        st_addr = 32'h0;
        st_data = 32'h0;
    endtask

    // Drive tx_ready (mode 0: always 1, mode 1: repeating 1,0,0,1) and check
    // up to max_bytes accepted bytes against the expected text.
    task automatic stream(input string tag, input int mode, input int max_bytes, output int rdn);
        int         got = 0;
        int         cyc = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [3:0] pat = 4'b1001;
        logic       rdy;
        rdn = 0;
        while (got < max_bytes && cyc < 400) begin
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
                chk({tag, "_hold_data"},  32'(tx_data),  32'(prev_data));
            end
            if (rd_en) rdn = rdn + 1;
            rdy = (mode == 0) ? 1'b1 : pat[cyc % 4];
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                if (got == 17) chk({tag, "_done_early"}, 32'(done), 32'd0);
                chk($sformatf("%s_byte%0d", tag, got), 32'(tx_data), 32'(exp_b[got]));
                got = got + 1;
            end
            prev_stall = tx_valid && !rdy;
            prev_data  = tx_data;
            tick();
            cyc = cyc + 1;
        end
        if (got < max_bytes) chk({tag, "_timeout_bytes"}, 32'(got), 32'(max_bytes));
        tx_ready = 1'b0;
    endtask

    task automatic check_finished(input string tag, input int rdn, input int exp_rdn);
        chk({tag, "_done"},      32'(done),      32'd1);
        chk({tag, "_core_halt"}, 32'(core_halt), 32'd1);
        chk({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
        chk({tag, "_rd_addr"},   rd_addr,        32'h108);
        chk({tag, "_rd_cnt"},    32'(rdn),       32'(exp_rdn));
    endtask

    initial begin
        int rdn;
        int act;
        rst_n    = 1'b0;
        st_en    = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        tx_ready = 1'b0;
        rd_data  = 32'h0;
        rd_data2 = 32'h0;
        tick();
        tick();
        check_reset("rst0");
        chk("rst0_empty_done", 32'(done2), 32'd0);
        rst_n = 1'b1;
        tick();

        // Non-trigger stores: wrong data to TOHOST, then 1 to a neighbouring address.
        st_en = 1'b1; st_addr = 32'h200; st_data = 32'h2;
        tick();
        st_addr = 32'h204; st_data = 32'h1;
        tick();
        st_en = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        act = 0;
        for (int i = 0; i < 6; i++) begin
            if (rd_en || tx_valid || core_halt || core_halt2) act = act + 1;
            tick();
        end
        chk("ignore_activity", 32'(act), 32'd0);

        // Full dump with tx_ready held high, checking trigger latency.
        tx_ready = 1'b1;
        do_trigger();
        chk("t1_core_halt", 32'(core_halt), 32'd1);
        chk("t1_rd_en",     32'(rd_en),     32'd1);
        chk("t1_rd_addr",   rd_addr,        32'h100);
        chk("t1_tx_valid",  32'(tx_valid),  32'd0);
        chk("t1_empty_halt", 32'(core_halt2), 32'd1);
        chk("t1_empty_done", 32'(done2),      32'd1);
        tick();
        chk("t2_tx_valid", 32'(tx_valid), 32'd0);
        chk("t2_rd_en",    32'(rd_en),    32'd0);
        tick();
        chk("t3_tx_valid", 32'(tx_valid), 32'd1);
        chk("t3_tx_data",  32'(tx_data),  32'h64);
        stream("s1", 0, 18, rdn);
        check_finished("s1", rdn, 1);

        // Second tohost write after completion must not restart anything.
        do_trigger();
        act = 0;
        for (int i = 0; i < 8; i++) begin
            if (rd_en || tx_valid) act = act + 1;
            tick();
        end
        chk("redo_activity",  32'(act),       32'd0);
        chk("redo_done",      32'(done),      32'd1);
        chk("redo_core_halt", 32'(core_halt), 32'd1);

        // Backpressured dump after a reset.
        rst_n = 1'b0;
        tick();
        check_reset("rst1");
        rst_n = 1'b1;
        tick();
        do_trigger();
        stream("s2", 1, 18, rdn);
        check_finished("s2", rdn, 2);

        // Abort after four bytes, then restart from the first word.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_trigger();
        stream("s3a", 0, 4, rdn);
        rst_n = 1'b0;
        tick();
        check_reset("abort");
        rst_n = 1'b1;
        tick();
        do_trigger();
        stream("s3b", 0, 18, rdn);
        check_finished("s3b", rdn, 2);

        chk("empty_activity", 32'(bad2),  32'd0);
        chk("empty_done_end", 32'(done2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
